// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS IF stage: PC owner, one-outstanding imem fetch, stall hold, delay-slot redirect
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop_sel,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_PC,
    output logic [31:0] out_instruction,
    output logic        out_valid
);

    localparam logic [1:0] ST_REQ  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    logic        handoff;
    logic        redir_taken;
    logic [31:0] tgt_aligned;

    assign tgt_aligned = redirect_target & 32'hFFFF_FFFC;

    always_comb begin
        imem_req        = (state_q == ST_REQ);
        imem_addr       = pc_q;
        out_PC          = pc_q;
        out_valid       = 1'b0;
        out_instruction = 32'h0;
        if (state_q == ST_WAIT && imem_ready) begin
            out_valid       = 1'b1;
            out_instruction = imem_rdata;
        end else if (state_q == ST_HOLD) begin
            out_valid       = 1'b1;
            out_instruction = inst_buf_q;
        end
    end

    // A redirect seen while stalled is dropped; ID re-presents it once the stall clears.
    assign handoff     = out_valid && !stop_sel;
    assign redir_taken = redirect && !stop_sel;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_buf_d   = inst_buf_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        case (state_q)
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_ready) begin
                    if (stop_sel) begin
                        inst_buf_d = imem_rdata;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (!stop_sel) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        // The instruction at handoff is the delay slot; only the PC after it is redirected.
        if (handoff) begin
            if (redirect)          pc_d = tgt_aligned;
            else if (redir_pend_q) pc_d = redir_tgt_q;
            else                   pc_d = pc_q + 32'd4;
            redir_pend_d = 1'b0;
        end else if (redir_taken) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = tgt_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            inst_buf_q   <= 32'h0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_buf_q   <= inst_buf_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop_sel;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] out_PC;
    logic [31:0] out_instruction;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stop_sel        (stop_sel),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .out_PC          (out_PC),
        .out_instruction (out_instruction),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch from the REQ cycle: nwait idle WAIT cycles, then ready with optional redirect at handoff.
    task automatic fetch(input logic [31:0] a, input int nwait, input logic [31:0] d,
                         input logic hr, input logic [31:0] ht);
        check("req", {31'h0, imem_req}, 32'd1);
        check("addr", imem_addr, a);
        check("req_valid", {31'h0, out_valid}, 32'd0);
        tick();
        for (int i = 0; i < nwait; i++) begin
            check("wait_valid", {31'h0, out_valid}, 32'd0);
            check("wait_instr", out_instruction, 32'h0);
            check("wait_req", {31'h0, imem_req}, 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = d;
        redirect = hr;
        redirect_target = ht;
        #1;
        check("ho_valid", {31'h0, out_valid}, 32'd1);
        check("ho_instr", out_instruction, d);
        check("ho_pc", out_PC, a);
        tick();
        imem_ready = 1'b0;
        redirect = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stop_sel = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_req", {31'h0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, 32'h0000_3000);
        check("rst_pc", out_PC, 32'h0000_3000);
        check("rst_instr", out_instruction, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'd0);

        // k=1 cadence: req at 0,2,4, handoff at 1,3,5
        fetch(32'h0000_3000, 0, 32'h2408_0001, 1'b0, 32'h0);
        fetch(32'h0000_3004, 0, 32'h2409_0002, 1'b0, 32'h0);
        fetch(32'h0000_3008, 0, 32'h240A_0003, 1'b0, 32'h0);

        // longer latency
        fetch(32'h0000_300C, 3, 32'h240B_0004, 1'b0, 32'h0);
        fetch(32'h0000_3010, 3, 32'h240C_0005, 1'b0, 32'h0);

        // ready under stall -> HOLD for 4 stalled cycles
        check("h_addr", imem_addr, 32'h0000_3014);
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'hAABB_CCDD;
        stop_sel = 1'b1;
        #1;
        check("h_bypass", out_instruction, 32'hAABB_CCDD);
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("h_valid", {31'h0, out_valid}, 32'd1);
            check("h_instr", out_instruction, 32'hAABB_CCDD);
            check("h_req", {31'h0, imem_req}, 32'd0);
            check("h_pc", out_PC, 32'h0000_3014);
            tick();
        end
        stop_sel = 1'b0;
        #1;
        check("h_release", {31'h0, out_valid}, 32'd1);
        tick();

        // redirect while delay slot 3018 is in WAIT
        check("ds_addr", imem_addr, 32'h0000_3018);
        tick();
        redirect = 1'b1;
        redirect_target = 32'h0000_3100;
        tick();
        redirect = 1'b0;
        redirect_target = 32'h0;
        tick();
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0000;
        #1;
        check("ds_valid", {31'h0, out_valid}, 32'd1);
        check("ds_pc", out_PC, 32'h0000_3018);
        tick();
        imem_ready = 1'b0;
        #1;
        // redirect at handoff, low bits dropped
        fetch(32'h0000_3100, 1, 32'h0800_0C80, 1'b1, 32'h0000_3201);

        // redirect with stop_sel=1 is ignored
        check("ign_addr", imem_addr, 32'h0000_3200);
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_2222;
        stop_sel = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h0000_3400;
        tick();
        imem_ready = 1'b0;
        tick();
        stop_sel = 1'b0;
        redirect = 1'b0;
        #1;
        check("ign_valid", {31'h0, out_valid}, 32'd1);
        tick();
        check("ign_next", imem_addr, 32'h0000_3204);

        // stalled redirect, then same redirect unstalled at handoff
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'h3333_4444;
        stop_sel = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h0000_3300;
        tick();
        imem_ready = 1'b0;
        stop_sel = 1'b0;
        #1;
        check("app_instr", out_instruction, 32'h3333_4444);
        tick();
        redirect = 1'b0;
        #1;
        check("app_next", imem_addr, 32'h0000_3300);

        // PC wrap
        fetch(32'h0000_3300, 0, 32'h5555_6666, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 0, 32'h7777_8888, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // reset mid-WAIT with a redirect pending
        tick();
        redirect = 1'b1;
        redirect_target = 32'h0000_3100;
        tick();
        redirect = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rw_req", {31'h0, imem_req}, 32'd1);
        check("rw_valid", {31'h0, out_valid}, 32'd0);
        fetch(32'h0000_3000, 0, 32'h9999_0000, 1'b0, 32'h0);
        check("rw_nopend", imem_addr, 32'h0000_3004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
